fetch_queue_unit: RTL
=====================

FETCH_QUEUE_UNIT -- requirements
Module: fetch_queue_unit

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning PC and memory address width in bits.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning instruction width; legal values are 16, 32 and 64.
REQ-003 The block SHALL have parameter QDEPTH, default 4, meaning fetch queue entries; it is a power of two, at least 2.
REQ-004 The block SHALL have parameter RESET_PC, default 0, meaning the first fetch address after reset.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port redirect_valid, input, 1 bit: branch/jump taken; load a new PC and flush.
REQ-008 The block SHALL have port redirect_pc, input, ADDR_W bits: the target PC, valid when redirect_valid=1.
REQ-009 The block SHALL have port imem_req, output, 1 bit: read request to instruction memory this cycle.
REQ-010 The block SHALL have port imem_addr, output, ADDR_W bits: the byte address of the request.
REQ-011 The block SHALL have port imem_rdata, input, DATA_W bits: read data, valid exactly one cycle after the accepted imem_req.
REQ-012 The block SHALL have port instr_valid, output, 1 bit: the queue head is valid for decode.
REQ-013 The block SHALL have port instr_ready, input, 1 bit: decode accepts the head.
REQ-014 The block SHALL have port instr_out, output, DATA_W bits: the head instruction.
REQ-015 The block SHALL have port pc_out, output, ADDR_W bits: the PC of the head instruction.
REQ-016 The block SHALL have port q_count, output, clog2(QDEPTH)+1 bits: current number of queue entries.

Function
REQ-017 The block SHALL hold state fetch_pc, an in-flight flag, a QDEPTH-entry {instr, pc} circular queue with read/write pointers, and a count.
REQ-018 The block SHALL drive imem_req combinationally as (!rst && !redirect_valid && count + inflight < QDEPTH) and imem_addr = fetch_pc.
REQ-019 On each imem_req=1 cycle, the block SHALL set inflight for the next cycle, tag it with imem_addr, and advance fetch_pc by DATA_W/8 with wrap modulo 2^ADDR_W.
REQ-020 In the cycle after the request, with no redirect, the block SHALL push imem_rdata and the tagged PC at the write pointer; every pushed entry is guaranteed space by REQ-018.
REQ-021 The queue SHALL be first-word-fall-through: instr_valid = (count != 0), and instr_out/pc_out come from the read pointer.
REQ-022 A transfer SHALL occur when instr_valid and instr_ready are both 1; the read pointer then advances.
REQ-023 On a simultaneous push and pop, count SHALL stay unchanged; this is legal when the queue is full (count=QDEPTH) only if the pop happens.
REQ-024 Pointers SHALL wrap modulo QDEPTH; count SHALL never exceed QDEPTH or drop below 0.
REQ-025 On redirect_valid=1, the block SHALL complete any transfer of that cycle, then at the edge set count=0, set both pointers to 0, clear inflight and discard any response arriving that cycle, and set fetch_pc = redirect_pc with the low log2(DATA_W/8) bits forced to 0.
REQ-026 Latency SHALL be as follows: redirect in cycle N, then imem_req with redirect_pc in cycle N+1, data in N+2, and instr_valid=1 in N+3.
REQ-027 Redirect on consecutive cycles SHALL be honoured; the last one wins and no request is issued while redirect_valid=1.
REQ-028 The head entry and its output SHALL stay stable while instr_valid=1 and instr_ready=0.

Reset
REQ-029 While rst=1, the block SHALL drive imem_req=0 and instr_valid=0, and at the edge set fetch_pc=RESET_PC, count=0, q_count=0, pointers=0 and inflight=0; rst overrides redirect_valid.
REQ-030 Reset asserted mid-operation SHALL discard all queued and in-flight instructions; after deassertion, the first request is to RESET_PC in the first cycle with rst=0.
REQ-031 Queue data storage SHALL NOT require reset; the outputs instr_out and pc_out are don't-care while instr_valid=0.

Verification
REQ-032 Cold start, instr_ready=1, memory returns addr as data: requests 0,4,8,..., instr_valid first high 2 cycles after rst drops, pc_out 0,4,8 in order, with one instruction per cycle sustained.
REQ-033 Backpressure, instr_ready=0, QDEPTH=4: exactly 4 requests are issued, then imem_req=0, q_count=4, head stays pc_out=0; raising ready resumes at addr 16 with no loss or duplication.
REQ-034 Redirect to 0x103 while 3 entries are queued and one is in flight: next cycle q_count=0, instr_valid=0, imem_addr=0x100, the stale response is dropped, and the next pc_out=0x100.
REQ-035 Wrap, ADDR_W=8, redirect to 0xF8: pc_out sequence is 0xF8, 0xFC, 0x00, 0x04.
REQ-036 Simultaneous events: redirect and pop in the same cycle pop the head and then flush; rst asserted with redirect_valid gives fetch_pc=RESET_PC.
REQ-037 Parameter sweep with DATA_W=16 and QDEPTH=8: PC steps by 2, and 8 entries fill before imem_req drops.

Source files
------------

// File: rtl/fetch_queue_unit.sv
// Instruction fetch front end: sequential PC generator feeding a small FWFT queue.
// One outstanding memory read at a time; redirect flushes queue and in-flight read.
module fetch_queue_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int QDEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      redirect_valid,
  input  logic [ADDR_W-1:0]         redirect_pc,
  output logic                      imem_req,
  output logic [ADDR_W-1:0]         imem_addr,
  input  logic [DATA_W-1:0]         imem_rdata,
  output logic                      instr_valid,
  input  logic                      instr_ready,
  output logic [DATA_W-1:0]         instr_out,
  output logic [ADDR_W-1:0]         pc_out,
  output logic [$clog2(QDEPTH):0]   q_count
);

  localparam int PW   = $clog2(QDEPTH);
  localparam int CW   = PW + 1;
  localparam int STEP = DATA_W / 8;
  localparam logic [ADDR_W-1:0] STEP_A     = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(STEP - 1);
  localparam logic [CW:0]       DEPTH_C    = (CW+1)'(QDEPTH);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] tag_pc_q, tag_pc_d;
  logic              inflight_q, inflight_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] instr_mem_q [QDEPTH];
  logic [ADDR_W-1:0] pc_mem_q    [QDEPTH];

  logic [CW:0] occupancy;
  logic        req, push, pop;

  // In-flight read is counted so that its response always finds a free slot.
  assign occupancy = {1'b0, count_q} + (CW+1)'(inflight_q);
  assign req       = !rst && !redirect_valid && (occupancy < DEPTH_C);
  assign push      = inflight_q && !redirect_valid && !rst;
  assign pop       = instr_valid && instr_ready;

  assign imem_req    = req;
  assign imem_addr   = fetch_pc_q;
  assign instr_valid = !rst && (count_q != '0);
  assign instr_out   = instr_mem_q[rd_ptr_q];
  assign pc_out      = pc_mem_q[rd_ptr_q];
  assign q_count     = count_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    tag_pc_d   = tag_pc_q;
    inflight_d = 1'b0;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (req) begin
      inflight_d = 1'b1;
      tag_pc_d   = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + STEP_A;
    end
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
    // Redirect wins over everything except the handshake already seen this cycle.
    if (redirect_valid) begin
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      inflight_d = 1'b0;
      fetch_pc_d = redirect_pc & ALIGN_MASK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      tag_pc_q   <= '0;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      tag_pc_q   <= tag_pc_d;
      inflight_q <= inflight_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= imem_rdata;
      pc_mem_q[wr_ptr_q]    <= tag_pc_q;
    end
  end

endmodule
